// File: rtl/controller_mc.sv
// rtl/controller_mc.sv - multi-cycle CPU controller with handshaked fetch and data memory
module controller_mc #(
  parameter int INST_W = 16,
  parameter int REG_AW = 4,
  parameter int IMM_W  = 8,
  parameter int ALU_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        psr,
  input  logic [INST_W-1:0] inst,
  input  logic              inst_valid,
  input  logic              mem_ready,
  output logic              inst_req,
  output logic              mem_req,
  output logic              MEM_WE,
  output logic              MEMC_MUX,
  output logic              BRANCH,
  output logic              JUMP,
  output logic              IMM_MUX,
  output logic              PSR_EN,
  output logic              PC_EN,
  output logic              WRITE,
  output logic              COND_RSLT,
  output logic [2:0]        WB_MUX,
  output logic [REG_AW-1:0] rDst,
  output logic [REG_AW-1:0] rSrc,
  output logic [IMM_W-1:0]  imm_val,
  output logic [ALU_W-1:0]  ALU_OP,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] ir;
  logic        cond_rslt;
  // run stays low for the first cycle after reset so no fetch is issued while rst is high
  logic        run;

  logic [3:0]  op;
  logic [3:0]  cond;
  logic        is_alu;
  logic        is_load;
  logic        is_stor;
  logic        is_lui;
  logic        is_bcond;
  logic        is_jcond;
  logic        fetch_go;

  assign op       = ir[15:12];
  assign cond     = ir[11:8];
  assign is_alu   = (op <= 4'd7);
  assign is_load  = (op == 4'h8);
  assign is_stor  = (op == 4'h9);
  assign is_lui   = (op == 4'hF);
  assign is_bcond = (op == 4'hC);
  assign is_jcond = (op == 4'hD);
  assign fetch_go = (state == S_FETCH) && run && inst_valid;

  // Instruction fields come straight from IR, so they are valid from DECODE until the next fetch
  assign rDst      = ir[8 +: REG_AW];
  assign rSrc      = ir[0 +: REG_AW];
  assign imm_val   = ir[0 +: IMM_W];
  assign COND_RSLT = cond_rslt;

  // Condition table over psr = {N,Z,F,L,C}; unlisted codes are false
  function automatic logic eval_cond(input logic [3:0] c, input logic [4:0] f);
    logic r;
    case (c)
      4'h0:    r = f[3];
      4'h1:    r = !f[3];
      4'h2:    r = f[0];
      4'h3:    r = !f[0];
      4'h4:    r = f[1];
      4'h5:    r = !f[1];
      4'h6:    r = f[4];
      4'h7:    r = !f[4];
      4'h8:    r = f[2];
      4'h9:    r = !f[2];
      4'hE:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // State register; reset returns to FETCH with fetching held off for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  // IR capture on an accepted fetch and condition capture in EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      ir        <= '0;
      cond_rslt <= 1'b0;
    end else begin
      if (fetch_go) begin
        ir <= inst[15:0];
      end
      if (state == S_EXEC) begin
        cond_rslt <= eval_cond(cond, psr);
      end
    end
  end

  // Next-state sequencing; handshakes stretch FETCH and MEM indefinitely
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (fetch_go) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = (is_load || is_stor) ? S_MEM : S_WB;
      S_MEM:    if (mem_ready) state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Static decode of the operand selects and ALU operation from IR
  always_comb begin
    ALU_OP  = '0;
    IMM_MUX = 1'b0;
    WB_MUX  = 3'd0;
    if (op == 4'h0) begin
      ALU_OP[3:0] = ir[7:4];
    end else if (is_alu) begin
      ALU_OP[4:0] = {2'b10, op[2:0]};
      IMM_MUX     = 1'b1;
    end
    if (is_load) begin
      WB_MUX = 3'd1;
    end else if (is_lui) begin
      WB_MUX = 3'd2;
    end
  end

  // Per-state strobes; WB strobes are single-cycle pulses
  always_comb begin
    inst_req = 1'b0;
    busy     = 1'b1;
    mem_req  = 1'b0;
    MEMC_MUX = 1'b0;
    MEM_WE   = 1'b0;
    PC_EN    = 1'b0;
    WRITE    = 1'b0;
    PSR_EN   = 1'b0;
    BRANCH   = 1'b0;
    JUMP     = 1'b0;
    case (state)
      S_FETCH: begin
        busy     = 1'b0;
        inst_req = run;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        MEMC_MUX = 1'b1;
        MEM_WE   = is_stor;
      end
      S_WB: begin
        PC_EN  = 1'b1;
        WRITE  = is_alu || is_lui || is_load;
        PSR_EN = is_alu;
        BRANCH = is_bcond && cond_rslt;
        JUMP   = is_jcond && cond_rslt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controller_mc.sv
// tb/tb_controller_mc.sv - randomized self-checking bench for controller_mc
module tb_controller_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  psr;
  logic [15:0] inst;
  logic        inst_valid;
  logic        mem_ready;
  logic        inst_req, mem_req, MEM_WE, MEMC_MUX, BRANCH, JUMP, IMM_MUX;
  logic        PSR_EN, PC_EN, WRITE, COND_RSLT, busy;
  logic [2:0]  WB_MUX;
  logic [3:0]  rDst, rSrc;
  logic [7:0]  imm_val;
  logic [4:0]  ALU_OP;

  int vectors = 0;
  int errors  = 0;

  controller_mc #(.INST_W(16), .REG_AW(4), .IMM_W(8), .ALU_W(5)) dut (
    .clk(clk), .rst(rst), .psr(psr), .inst(inst), .inst_valid(inst_valid),
    .mem_ready(mem_ready), .inst_req(inst_req), .mem_req(mem_req), .MEM_WE(MEM_WE),
    .MEMC_MUX(MEMC_MUX), .BRANCH(BRANCH), .JUMP(JUMP), .IMM_MUX(IMM_MUX),
    .PSR_EN(PSR_EN), .PC_EN(PC_EN), .WRITE(WRITE), .COND_RSLT(COND_RSLT),
    .WB_MUX(WB_MUX), .rDst(rDst), .rSrc(rSrc), .imm_val(imm_val), .ALU_OP(ALU_OP),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {inst_req,busy,mem_req,MEM_WE,MEMC_MUX,PC_EN,WRITE,PSR_EN,BRANCH,JUMP}
  function automatic logic [9:0] ctl();
    return {inst_req, busy, mem_req, MEM_WE, MEMC_MUX, PC_EN, WRITE, PSR_EN, BRANCH, JUMP};
  endfunction

  function automatic logic [24:0] fields();
    return {rDst, rSrc, imm_val, ALU_OP, IMM_MUX, WB_MUX};
  endfunction

  // Reference condition: codes pair up as (flag, !flag) for Z, C, L, N, F; E is always
  function automatic bit cond_ref(input logic [3:0] c, input logic [4:0] p);
    logic f;
    if (c == 4'hE) return 1'b1;
    if (c > 4'h9) return 1'b0;
    case (c >> 1)
      0: f = p[3];
      1: f = p[0];
      2: f = p[1];
      3: f = p[4];
      default: f = p[2];
    endcase
    return c[0] ? !f : f;
  endfunction

  function automatic logic [24:0] fields_ref(input logic [15:0] ins);
    int op;
    logic [4:0] alu;
    logic       immm;
    logic [2:0] wbm;
    op   = int'(ins[15:12]);
    alu  = (op == 0) ? {1'b0, ins[7:4]} : ((op <= 7) ? 5'(16 + op) : 5'd0);
    immm = (op >= 1 && op <= 7);
    wbm  = (op == 8) ? 3'd1 : ((op == 15) ? 3'd2 : 3'd0);
    return {ins[11:8], ins[3:0], ins[7:0], alu, immm, wbm};
  endfunction

  // One instruction: stall cycles, then the timeline FETCH,DECODE,EXEC,[MEM x (w+1)],WB
  task automatic run_instr(input logic [15:0] ins, input int stall, input int w,
                           input int psr_exec, input string name, output int memc);
    int op;
    bit is_mem;
    int wb_k;
    bit c;
    logic [9:0] o, e;
    op     = int'(ins[15:12]);
    is_mem = (op == 8 || op == 9);
    wb_k   = is_mem ? 4 + w : 3;
    c      = 1'b0;
    memc   = 0;
    for (int s = 0; s < stall; s++) begin
      o = ctl();
      vectors++;
      if (o !== 10'b10_0000_0000) begin
        errors++;
        $display("FAIL %s stall%0d ctl: got %b want %b", name, s, o, 10'b10_0000_0000);
      end
      inst_valid = 1'b0;
      inst       = 16'($urandom);
      psr        = 5'($urandom);
      mem_ready  = 1'($urandom);
      step();
    end
    for (int k = 0; k <= wb_k; k++) begin
      o = ctl();
      e = '0;
      if (k == 0) begin
        e[9] = 1'b1;
      end else begin
        e[8] = 1'b1;
        if (is_mem && k >= 3 && k < wb_k) begin
          e[7] = 1'b1;
          e[6] = (op == 9);
          e[5] = 1'b1;
        end
        if (k == wb_k) begin
          e[4] = 1'b1;
          e[3] = (op <= 8) || (op == 15);
          e[2] = (op <= 7);
          e[1] = (op == 12) && c;
          e[0] = (op == 13) && c;
        end
      end
      if (mem_req === 1'b1) memc++;
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s k%0d ctl: got %b want %b", name, k, o, e);
      end
      if (k == 1 || k == wb_k) begin
        vectors++;
        if (fields() !== fields_ref(ins)) begin
          errors++;
          $display("FAIL %s k%0d fields: got %h want %h", name, k, fields(), fields_ref(ins));
        end
      end
      if (k == wb_k && (op == 12 || op == 13)) begin
        vectors++;
        if (COND_RSLT !== c) begin
          errors++;
          $display("FAIL %s cond_rslt: got %b want %b", name, COND_RSLT, c);
        end
      end
      inst_valid = (k == 0) ? 1'b1 : 1'($urandom);
      inst       = (k == 0) ? ins : 16'($urandom);
      psr        = (k == 2 && psr_exec >= 0) ? 5'(psr_exec) : 5'($urandom);
      if (k == 2) c = cond_ref(ins[11:8], psr);
      if (is_mem && k >= 3 && k < wb_k) mem_ready = (k - 3 == w);
      else mem_ready = 1'($urandom);
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; inst_valid = 1'b1; inst = 16'h0152; psr = '0; mem_ready = 1'b1;
    step();
    step();
    vectors++;
    if ({ctl(), fields(), COND_RSLT} !== 36'd0) begin
      errors++;
      $display("FAIL reset outputs: got %h want 0", {ctl(), fields(), COND_RSLT});
    end
    rst = 1'b0; inst_valid = 1'b0;
    step();
    vectors++;
    if (ctl() !== 10'b10_0000_0000) begin
      errors++;
      $display("FAIL reset release ctl: got %b want %b", ctl(), 10'b10_0000_0000);
    end
  endtask

  task automatic test_rtype();
    int m;
    run_instr(16'h0152, 0, 0, -1, "rtype", m);
  endtask

  task automatic test_imm();
    int m;
    run_instr(16'h53F0, 0, 0, -1, "imm", m);
  endtask

  task automatic test_load();
    int m;
    run_instr(16'h8704, 0, 3, -1, "load", m);
    vectors++;
    if (m != 4) begin
      errors++;
      $display("FAIL load mem_req cycles: got %0d want 4", m);
    end
  endtask

  task automatic test_stor();
    int m;
    run_instr(16'h9704, 0, 1, -1, "stor", m);
    vectors++;
    if (m != 2) begin
      errors++;
      $display("FAIL stor mem_req cycles: got %0d want 2", m);
    end
  endtask

  task automatic test_bcond();
    int m;
    run_instr(16'hC0FE, 0, 0, 5'b01000, "bcond_z1", m);
    run_instr(16'hC0FE, 0, 0, 5'b00000, "bcond_z0", m);
  endtask

  task automatic test_jcond();
    int m;
    run_instr(16'hDE03, 0, 0, -1, "jcond_uc", m);
    run_instr(16'hDB03, 0, 0, 5'b11111, "jcond_b", m);
  endtask

  task automatic test_fetch_stall();
    int m;
    run_instr(16'h2A5C, 5, 0, -1, "fetch_stall", m);
  endtask

  task automatic test_back_to_back();
    int m;
    for (int i = 0; i < 6; i++) begin
      run_instr({4'($urandom_range(0, 7)), 12'($urandom)}, 0, 0, -1, "b2b", m);
    end
  endtask

  task automatic test_reset_mid_mem();
    int m;
    inst_valid = 1'b1; inst = 16'h8704; mem_ready = 1'b0;
    step();
    inst_valid = 1'b0;
    step();
    step();
    vectors++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL midmem enter mem_req: got %b want 1", mem_req);
    end
    rst = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({ctl(), fields(), COND_RSLT} !== 36'd0) begin
        errors++;
        $display("FAIL midmem rst%0d outputs: got %h want 0", i, {ctl(), fields(), COND_RSLT});
      end
    end
    rst = 1'b0; mem_ready = 1'b0;
    step();
    vectors++;
    if (ctl() !== 10'b10_0000_0000) begin
      errors++;
      $display("FAIL midmem release ctl: got %b want %b", ctl(), 10'b10_0000_0000);
    end
    run_instr(16'h1234, 0, 0, -1, "after_midmem", m);
  endtask

  task automatic test_random();
    int m;
    for (int i = 0; i < 200; i++) begin
      run_instr(16'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), -1, "random", m);
    end
  endtask

  initial begin
    rst = 1'b1; psr = '0; inst = '0; inst_valid = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_imm();
    test_load();
    test_stor();
    test_bcond();
    test_jcond();
    test_fetch_stall();
    test_back_to_back();
    test_reset_mid_mem();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
